// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared types and constants for the iterative multiply/divide unit
package multdiv_pkg;

  localparam int WIDTH = 32;
  localparam int STEPS = 32;
  localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

endpackage

// File: rtl/multdiv_unit_div_step.sv
// rtl/multdiv_unit_div_step.sv - one restoring-division step: shift, trial subtract, restore
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The partial remainder stays below the divisor, so WIDTH+1 bits hold the shifted value
  // and the top bit of the trial difference acts as the borrow.
  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor_i};

  always_comb begin
    rem_o = shifted[WIDTH-1:0];
    quo_o = {quo_i[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_o = trial[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - 32-cycle signed Booth multiplier / restoring divider for the execute stage
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = multdiv_pkg::WIDTH,
  parameter int STEPS = multdiv_pkg::STEPS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [4:0]       tag_in,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy,
  output logic [4:0]       tag_out
);

  localparam int CW = $clog2(STEPS);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [4:0]       tag_q, tag_d;
  // Booth accumulator carries one guard bit so that subtracting INT_MIN cannot overflow.
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic             q1_q, q1_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             neg_q, neg_d;
  logic             dzero_q, dzero_d;
  logic             dovf_q, dovf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
  logic [4:0]       tag_out_q, tag_out_d;

  logic             start;
  op_e              start_op;
  logic             last_step;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   acc_n;
  logic [WIDTH-1:0] mq_n;
  logic [2*WIDTH-1:0] mul_prod;
  logic             mul_ovf;
  logic [WIDTH-1:0] rem_n, quo_n;
  logic [WIDTH-1:0] div_res;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign start_op  = ctrl_MULT ? OP_MUL : OP_DIV;
  assign last_step = (cnt_q == CW'(STEPS - 1));

  assign a_abs = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
  assign b_abs = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

  always_comb begin
    booth_sum = acc_q;
    case ({mq_q[0], q1_q})
      2'b01:   booth_sum = acc_q + {mcand_q[WIDTH-1], mcand_q};
      2'b10:   booth_sum = acc_q - {mcand_q[WIDTH-1], mcand_q};
      default: booth_sum = acc_q;
    endcase
  end

  assign acc_n    = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
  assign mq_n     = {booth_sum[0], mq_q[WIDTH-1:1]};
  assign mul_prod = {acc_n[WIDTH-1:0], mq_n};
  assign mul_ovf  = (mul_prod[2*WIDTH-1:WIDTH] != {WIDTH{mul_prod[WIDTH-1]}});

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvsr_q),
    .rem_o     (rem_n),
    .quo_o     (quo_n)
  );

  assign div_res = neg_q ? (~quo_n + 1'b1) : quo_n;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tag_d     = tag_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    q1_d      = q1_q;
    mcand_d   = mcand_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_d     = neg_q;
    dzero_d   = dzero_q;
    dovf_d    = dovf_q;
    result_d  = result_q;
    exc_d     = exc_q;
    rdy_d     = 1'b0;
    tag_out_d = tag_out_q;

    if (start) begin
      cnt_d = '0;
      tag_d = tag_in;
      if (start_op == OP_MUL) begin
        state_d = MUL;
        acc_d   = '0;
        mq_d    = data_operandB;
        q1_d    = 1'b0;
        mcand_d = data_operandA;
      end else begin
        state_d = DIV;
        rem_d   = '0;
        quo_d   = a_abs;
        dvsr_d  = b_abs;
        neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        dzero_d = (data_operandB == '0);
        dovf_d  = (data_operandA == INT_MIN) && (data_operandB == {WIDTH{1'b1}});
      end
    end else begin
      case (state_q)
        MUL: begin
          acc_d = acc_n;
          mq_d  = mq_n;
          q1_d  = mq_q[0];
          cnt_d = cnt_q + 1'b1;
          if (last_step) begin
            state_d   = DONE;
            cnt_d     = '0;
            result_d  = mul_prod[WIDTH-1:0];
            exc_d     = mul_ovf;
            rdy_d     = 1'b1;
            tag_out_d = tag_q;
          end
        end
        DIV: begin
          rem_d = rem_n;
          quo_d = quo_n;
          cnt_d = cnt_q + 1'b1;
          if (last_step) begin
            state_d   = DONE;
            cnt_d     = '0;
            result_d  = dzero_q ? '0 : div_res;
            exc_d     = dzero_q | dovf_q;
            rdy_d     = 1'b1;
            tag_out_d = tag_q;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tag_q     <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      q1_q      <= 1'b0;
      mcand_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_q     <= 1'b0;
      dzero_q   <= 1'b0;
      dovf_q    <= 1'b0;
      result_q  <= '0;
      exc_q     <= 1'b0;
      rdy_q     <= 1'b0;
      tag_out_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tag_q     <= tag_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      q1_q      <= q1_d;
      mcand_q   <= mcand_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_q     <= neg_d;
      dzero_q   <= dzero_d;
      dovf_q    <= dovf_d;
      result_q  <= result_d;
      exc_q     <= exc_d;
      rdy_q     <= rdy_d;
      tag_out_q <= tag_out_d;
    end
  end

  // The start term lets the pipeline stall in the very cycle the operation is issued.
  assign busy           = start | (state_q == MUL) | (state_q == DIV);
  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign tag_out        = tag_out_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// tb/tb_multdiv_unit.sv - directed self-checking bench for multdiv_unit
module tb_multdiv_unit;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [4:0]  tag_in;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;
  logic [4:0]  tag_out;

  int n_checks = 0;
  int n_pass   = 0;

  multdiv_unit dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .tag_in         (tag_in),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy),
    .tag_out        (tag_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Present a start pulse for one cycle; returns busy/RDY as seen during that cycle.
  task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t, output logic busy_pre, output logic rdy_pre);
    @(negedge clock);
    ctrl_MULT = m;
    ctrl_DIV = d;
    data_operandA = a;
    data_operandB = b;
    tag_in = t;
    #1;
    busy_pre = busy;
    rdy_pre = data_resultRDY;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = 32'hDEAD_BEEF;
    data_operandB = 32'h0BAD_F00D;
    tag_in = 5'd0;
  endtask

  task automatic wait_rdy(output int lat, output int busy_low, output logic busy_end);
    lat = -1;
    busy_low = 0;
    busy_end = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        lat = i;
        busy_end = busy;
        break;
      end
      if (!busy) busy_low++;
    end
  endtask

  task automatic do_op(input string name, input logic m, input logic d, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] t,
                       input logic [31:0] exp_res, input logic exp_exc);
    logic bp, rp, be;
    int   lat, bl;
    start_op(m, d, a, b, t, bp, rp);
    wait_rdy(lat, bl, be);
    check({name, "_latency"}, 64'(lat), 64'd32);
    check({name, "_result"}, 64'(data_result), 64'(exp_res));
    check({name, "_exc"}, 64'(data_exception), 64'(exp_exc));
    check({name, "_tag"}, 64'(tag_out), 64'(t));
  endtask

  initial begin
    logic bp, rp, be;
    int   lat, bl, spurious;

    reset = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    tag_in = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_result", 64'(data_result), 64'd0);
    check("rst_exc", 64'(data_exception), 64'd0);
    check("rst_rdy", 64'(data_resultRDY), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tag", 64'(tag_out), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // 3 * -7 with full busy/strobe timing
    start_op(1'b1, 1'b0, 32'd3, 32'hFFFF_FFF9, 5'd5, bp, rp);
    check("mul1_busy_start", 64'(bp), 64'd1);
    wait_rdy(lat, bl, be);
    check("mul1_latency", 64'(lat), 64'd32);
    check("mul1_busy_gaps", 64'(bl), 64'd0);
    check("mul1_busy_after", 64'(be), 64'd0);
    check("mul1_result", 64'(data_result), 64'hFFFF_FFEB);
    check("mul1_exc", 64'(data_exception), 64'd0);
    check("mul1_tag", 64'(tag_out), 64'd5);
    @(posedge clock);
    #1;
    check("mul1_rdy_drop", 64'(data_resultRDY), 64'd0);
    check("mul1_result_hold", 64'(data_result), 64'hFFFF_FFEB);
    check("mul1_tag_hold", 64'(tag_out), 64'd5);

    do_op("mul_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd1, 32'h0, 1'b1);
    do_op("mul_max", 1'b1, 1'b0, 32'h7FFF_FFFF, 32'd1, 5'd2, 32'h7FFF_FFFF, 1'b0);
    do_op("div_neg", 1'b0, 1'b1, 32'hFFFF_FFEA, 32'd5, 5'd3, 32'hFFFF_FFFC, 1'b0);
    do_op("div_zero", 1'b0, 1'b1, 32'd7, 32'd0, 5'd4, 32'h0, 1'b1);
    do_op("div_ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h8000_0000, 1'b1);
    do_op("both_high", 1'b1, 1'b1, 32'd12, 32'd4, 5'd7, 32'd48, 1'b0);

    // Back-to-back: issue DIV 999/1 during the DONE cycle of the previous op
    start_op(1'b0, 1'b1, 32'd999, 32'd1, 5'd8, bp, rp);
    check("b2b_old_rdy", 64'(rp), 64'd1);
    check("b2b_busy", 64'(bp), 64'd1);
    wait_rdy(lat, bl, be);
    check("b2b_latency", 64'(lat), 64'd32);
    check("b2b_result", 64'(data_result), 64'd999);
    check("b2b_tag", 64'(tag_out), 64'd8);

    // Restart: DIV 100/3 aborted by MULT 6*7 at E10
    repeat (3) @(posedge clock);
    start_op(1'b0, 1'b1, 32'd100, 32'd3, 5'd9, bp, rp);
    spurious = 0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) spurious++;
    end
    start_op(1'b1, 1'b0, 32'd6, 32'd7, 5'd10, bp, rp);
    wait_rdy(lat, bl, be);
    check("restart_latency", 64'(lat), 64'd32);
    check("restart_result", 64'(data_result), 64'd42);
    check("restart_tag", 64'(tag_out), 64'd10);
    for (int i = 1; i <= 15; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) spurious++;
    end
    check("restart_spurious", 64'(spurious), 64'd0);

    // Reset in the middle of a MULT
    start_op(1'b1, 1'b0, 32'd5, 32'd5, 5'd11, bp, rp);
    repeat (14) @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_result", 64'(data_result), 64'd0);
    check("midrst_tag", 64'(tag_out), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_rdy", 64'(data_resultRDY), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    spurious = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) spurious++;
    end
    check("midrst_no_rdy", 64'(spurious), 64'd0);
    do_op("post_rst", 1'b1, 1'b0, 32'd2, 32'd2, 5'd12, 32'd4, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
